// File: rtl/apb_chk_pkg.sv
// Shared types for the APB protocol checker:
// FSM states, error bit indices and the SETUP snapshot.
package apb_chk_pkg;

   typedef enum logic [1:0] {
      IDLE,
      SETUP,
      ACCESS,
      DONE
   } state_t;

   localparam int NERR          = 8;
   localparam int E_PSEL_MULTI  = 0;
   localparam int E_EN_NO_SETUP = 1;
   localparam int E_SETUP_NO_EN = 2;
   localparam int E_CTRL_CHG    = 3;
   localparam int E_EN_DROP     = 4;
   localparam int E_TIMEOUT     = 5;
   localparam int E_EN_STUCK    = 6;
   localparam int E_STRB_RD     = 7;

   // Snapshot fields are sized for the widest supported bus;
   // narrower instances zero-extend into them.
   localparam int MAX_AW  = 64;
   localparam int MAX_DW  = 1024;
   localparam int MAX_SEL = 64;

   typedef struct packed {
      logic [MAX_SEL-1:0]  sel;
      logic [MAX_AW-1:0]   addr;
      logic                write;
      logic [MAX_DW-1:0]   wdata;
      logic [MAX_DW/8-1:0] strb;
      logic [2:0]          prot;
   } snap_t;

endpackage

// File: rtl/apb_chk_err_log.sv
// Violation log: one-cycle pulses, sticky flags and a
// saturating count of cycles carrying any new violation.
module apb_chk_err_log #(
   parameter int NERR  = 8,
   parameter int CNT_W = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             clr,
   input  logic [NERR-1:0]  err,
   output logic [NERR-1:0]  sticky,
   output logic [NERR-1:0]  pulse,
   output logic [CNT_W-1:0] count
);

   logic any;
   assign any = |err;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         sticky <= '0;
         pulse  <= '0;
         count  <= '0;
      end else begin
         pulse <= err;
         if (clr) begin
            sticky <= err;
            count  <= any ? CNT_W'(1) : '0;
         end else begin
            sticky <= sticky | err;
            if (any && count != '1)
               count <= count + CNT_W'(1);
         end
      end
   end

endmodule

// File: rtl/apb_protocol_checker.sv
// Passive APB3/APB4 bus monitor: tracks SETUP/ACCESS and
// reports protocol violations and completed transfers.
module apb_protocol_checker
   import apb_chk_pkg::*;
#(
   parameter int AW          = 32,
   parameter int DW          = 32,
   parameter int NSEL        = 16,
   parameter int APB4        = 0,
   parameter int TIMEOUT_CYC = 256,
   parameter int CNT_W       = 16
) (
   input  logic                    PCLK,
   input  logic                    PRESETn,
   input  logic [AW-1:0]           PADDR,
   input  logic [DW-1:0]           PWDATA,
   input  logic [DW-1:0]           PRDATA,
   input  logic [NSEL-1:0]         PSEL,
   input  logic                    PWRITE,
   input  logic                    PENABLE,
   input  logic                    PREADY,
   input  logic                    PSLVERR,
   input  logic [DW/8-1:0]         PSTRB,
   input  logic [2:0]              PPROT,
   input  logic                    err_clr,
   output logic [7:0]              err_sticky,
   output logic [7:0]              err_pulse,
   output logic [CNT_W-1:0]        err_count,
   output logic                    xfer_done,
   output logic                    xfer_write,
   output logic                    xfer_slverr,
   output logic [$clog2(NSEL)-1:0] xfer_sel
);

   localparam int SW = $clog2(NSEL);
   localparam int WW =
      (TIMEOUT_CYC > 0) ? $clog2(TIMEOUT_CYC + 1) : 1;
   localparam logic [WW-1:0] TOV = WW'(TIMEOUT_CYC);

   state_t          state_q, state_d;
   snap_t           snap_q, snap_d, cur;
   logic [WW-1:0]   wait_q, wait_d;
   logic [NERR-1:0] err;
   logic            done_d;
   logic            setup_cyc, txn, chg;
   logic            unused_prdata;

   assign unused_prdata = ^PRDATA;

   function automatic logic [SW-1:0] low_idx(
      input logic [NSEL-1:0] s
   );
      logic [SW-1:0] r;
      r = '0;
      for (int i = NSEL - 1; i >= 0; i--)
         if (s[i]) r = SW'(i);
      return r;
   endfunction

   always_comb begin
      cur = '0;
      cur.sel[NSEL-1:0] = PSEL;
      cur.addr[AW-1:0]  = PADDR;
      cur.write         = PWRITE;
      cur.wdata[DW-1:0] = PWDATA;
      if (APB4 != 0) begin
         cur.strb[DW/8-1:0] = PSTRB;
         cur.prot           = PPROT;
      end
   end

   assign setup_cyc = (|PSEL) && !PENABLE;
   assign txn = setup_cyc || (PENABLE &&
      (state_q == SETUP || state_q == ACCESS));

   // Write data only matters while the captured transfer is a write.
   assign chg = (cur.sel != snap_q.sel) ||
                (cur.addr != snap_q.addr) ||
                (cur.write != snap_q.write) ||
                (snap_q.write && cur.wdata != snap_q.wdata) ||
                (cur.strb != snap_q.strb) ||
                (cur.prot != snap_q.prot);

   always_comb begin
      state_d = state_q;
      snap_d  = snap_q;
      wait_d  = wait_q;
      done_d  = 1'b0;
      err     = '0;
      err[E_PSEL_MULTI] = (PSEL & (PSEL - NSEL'(1))) != '0;
      err[E_STRB_RD] = (APB4 != 0) && txn && !PWRITE && (|PSTRB);
      unique case (state_q)
         IDLE, DONE: begin
            err[E_EN_NO_SETUP] = PENABLE;
            err[E_EN_STUCK]    = (state_q == DONE) && PENABLE;
            state_d = setup_cyc ? SETUP : IDLE;
            if (setup_cyc) snap_d = cur;
         end
         SETUP: begin
            if (PENABLE) begin
               err[E_CTRL_CHG] = chg;
               wait_d = '0;
               if (PREADY) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else begin
                  state_d = ACCESS;
                  wait_d  = WW'(1);
                  err[E_TIMEOUT] = (TIMEOUT_CYC == 1);
               end
            end else begin
               err[E_SETUP_NO_EN] = 1'b1;
               state_d = setup_cyc ? SETUP : IDLE;
               if (setup_cyc) snap_d = cur;
            end
         end
         ACCESS: begin
            if (PENABLE) begin
               err[E_CTRL_CHG] = chg;
               if (PREADY) begin
                  state_d = DONE;
                  done_d  = 1'b1;
               end else if (TIMEOUT_CYC != 0 && wait_q != TOV) begin
                  wait_d = wait_q + WW'(1);
                  err[E_TIMEOUT] = (wait_d == TOV);
               end
            end else begin
               err[E_EN_DROP] = 1'b1;
               state_d = setup_cyc ? SETUP : IDLE;
               if (setup_cyc) snap_d = cur;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge PCLK) begin
      if (!PRESETn) begin
         state_q     <= IDLE;
         snap_q      <= '0;
         wait_q      <= '0;
         xfer_done   <= 1'b0;
         xfer_write  <= 1'b0;
         xfer_slverr <= 1'b0;
         xfer_sel    <= '0;
      end else begin
         state_q   <= state_d;
         snap_q    <= snap_d;
         wait_q    <= wait_d;
         xfer_done <= done_d;
         if (done_d) begin
            xfer_write  <= snap_q.write;
            xfer_slverr <= PSLVERR;
            xfer_sel    <= low_idx(snap_q.sel[NSEL-1:0]);
         end
      end
   end

   apb_chk_err_log #(
      .NERR  (NERR),
      .CNT_W (CNT_W)
   ) u_log (
      .clk    (PCLK),
      .rst_n  (PRESETn),
      .clr    (err_clr),
      .err    (err),
      .sticky (err_sticky),
      .pulse  (err_pulse),
      .count  (err_count)
   );

endmodule

// File: doc/apb_protocol_checker.md
Name: apb_protocol_checker

Overview:
- Synthesizable, parametrised APB3/APB4 protocol checker. Successor to the simulation-only assertion interface.
- Passively snoops one APB bus through a SETUP/ACCESS tracking FSM. Reports protocol violations as sticky flags, one-cycle pulses and a saturating counter, plus a per-transfer completion strobe.
- Sits beside the bus in RTL, so it is usable in emulation and silicon debug as well as simulation.

Parameters:
- AW, 32, PADDR width
- DW, 32, PWDATA/PRDATA width (multiple of 8)
- NSEL, 16, PSEL width (number of slaves)
- APB4, 0, 1 enables PSTRB/PPROT checks; 0 ignores those inputs
- TIMEOUT_CYC, 256, maximum PREADY-low ACCESS cycles; 0 disables the timeout check
- CNT_W, 16, error counter width

Ports:
- PCLK  in  1  bus clock; all logic on rising edge
- PRESETn  in  1  synchronous active-low reset
- PADDR  in  AW  address
- PWDATA  in  DW  write data
- PRDATA  in  DW  read data (snooped only)
- PSEL  in  NSEL  slave selects
- PWRITE  in  1  direction
- PENABLE  in  1  access phase
- PREADY  in  1  slave ready
- PSLVERR  in  1  slave error
- PSTRB  in  DW/8  write strobes (APB4)
- PPROT  in  3  protection (APB4)
- err_clr  in  1  clears err_sticky and err_count
- err_sticky  out  8  latched violation flags
- err_pulse  out  8  violations detected at the previous edge
- err_count  out  CNT_W  saturating count of cycles with at least one violation
- xfer_done  out  1  one-cycle strobe per completed transfer
- xfer_write  out  1  PWRITE of the completed transfer
- xfer_slverr  out  1  PSLVERR of the completed transfer
- xfer_sel  out  $clog2(NSEL)  index of the selected slave

Behaviour:
- Clock and reset: one clock, PCLK. Reset is synchronous and active-low on PRESETn.
- Reset values: PRESETn low at a PCLK edge sets state IDLE, zeroes every output, wait counter and snapshot. No checks are made in any cycle where PRESETn is sampled low. Reset mid-transfer abandons that transfer silently.
- Timing: all outputs are registered. A violation in the inputs sampled at edge N appears on err_pulse, err_sticky and err_count after edge N.
- Error bits:
  - 0 PSEL_MULTI: PSEL not onehot0, checked every cycle, any state.
  - 1 EN_NO_SETUP: PENABLE high in IDLE or DONE.
  - 2 SETUP_NO_EN: PENABLE low in the cycle after a SETUP.
  - 3 CTRL_CHG: PSEL, PADDR, PWRITE, PWDATA (writes only), PSTRB or PPROT (APB4 only) differs from the SETUP snapshot during ACCESS.
  - 4 EN_DROP: PENABLE low in ACCESS before PREADY.
  - 5 TIMEOUT: wait counter equals TIMEOUT_CYC; flagged once per transfer.
  - 6 EN_STUCK: PENABLE high in the cycle after completion.
  - 7 STRB_RD: APB4 only; PSTRB nonzero in SETUP or ACCESS of a read.
- FSM states: IDLE, SETUP, ACCESS, DONE. "Setup cycle" means PSEL!=0 and PENABLE=0.
  - IDLE/DONE: a setup cycle captures the snapshot (PADDR, PWRITE, PWDATA, PSTRB, PPROT, PSEL) and goes to SETUP. Otherwise go to IDLE. DONE additionally applies the EN_STUCK check.
  - SETUP, PENABLE=1: compare against the snapshot and clear the wait counter. PREADY=1 goes to DONE; otherwise go to ACCESS with the wait counter at 1.
  - SETUP, PENABLE=0: flag SETUP_NO_EN. If PSEL!=0, recapture and stay in SETUP; else go to IDLE.
  - ACCESS, PENABLE=1: compare against the snapshot. PREADY=1 goes to DONE. Otherwise the wait counter increments, saturating at TIMEOUT_CYC; TIMEOUT fires on the edge it reaches TIMEOUT_CYC. The FSM stays in ACCESS.
  - ACCESS, PENABLE=0: flag EN_DROP, then handle as IDLE (a setup cycle recaptures).
- Completion: the edge taken into DONE pulses xfer_done and registers xfer_write, xfer_slverr and xfer_sel (the encoded index of the snapshot PSEL). If PSEL_MULTI is set in the snapshot, xfer_sel is the lowest set index. Zero-wait transfers (PREADY high in the first ACCESS cycle) are legal.
- Error log:
  - err_sticky |= new errors.
  - err_count increments by 1 per cycle with any new error and saturates at all-ones.
  - err_clr together with a new error: sticky equals the new bits only; count equals 1.
  - err_clr alone zeroes both.

Decomposition:
- Package apb_chk_pkg holds:
  - state enum (IDLE, SETUP, ACCESS, DONE);
  - localparam indices for the 8 error bits;
  - NERR = 8;
  - the snapshot struct type.
- One sub-module, apb_chk_err_log: sticky/pulse/saturating-counter logic, parametrised by NERR and CNT_W.

Test Plan:
1. Legal write, PSEL=16'h0004, 2 wait states, then legal read with 0 waits. Response: err_sticky=0. xfer_done pulses twice: first xfer_write=1, xfer_sel=2; then xfer_write=0.
2. PADDR changes from 32'h100 to 32'h104 in the second ACCESS cycle. Response: err_pulse=8'h08 one cycle after that edge, err_count=1, transfer still completes.
3. TIMEOUT_CYC=4, PREADY held low for 10 cycles. Response: err_pulse[5] high exactly once, after the 4th wait edge; err_count=1.
4. PSEL=16'h0003 for one cycle with err_clr asserted on that same edge, after an earlier error. Response: err_sticky=8'h01, err_count=1.
5. PENABLE held high the cycle after PREADY, with APB4=1 and a read carrying PSTRB=4'hF. Response: err_sticky has bits 6 and 7 set.
6. PRESETn low for 1 cycle mid-ACCESS, then a fresh legal transfer. Response: all outputs 0 after reset, no EN_DROP flagged, next transfer completes clean.
